sdram_dma_fifo: RTL and testbench
=================================

SDRAM_DMA_FIFO -- requirements
Module: sdram_dma_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, master data width in bits; legal values are 16 and 32; BYTES = DATA_W/8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, read-to-write buffer depth in words; legal values are powers of 2 from 2 to 64.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have Avalon-MM slave s1 ports:
- avs_s1_chipselect in 1
- avs_s1_address in 3
- avs_s1_read in 1
- avs_s1_write in 1
- avs_s1_writedata in 32
- avs_s1_byteenable in 4 (ignored; full-word access)
- avs_s1_readdata out 32
- avs_s1_waitrequest out 1
REQ-007 SHALL have read master ports:
- avm_read_address out 32
- avm_read_read out 1
- avm_read_readdata in DATA_W
- avm_read_waitrequest in 1
REQ-008 SHALL have write master ports:
- avm_write_address out 32
- avm_write_write out 1
- avm_write_writedata out DATA_W
- avm_write_waitrequest in 1
REQ-009 SHALL have port irq, output, 1 bit: level interrupt equal to STATUS.done AND CONTROL[2].

Function
REQ-010 SHALL decode the register map as follows:
- 0 S_ADDR rw
- 1 D_ADDR rw
- 2 LENGTH rw (bytes)
- 3 CONTROL rw: [0] src fixed, [1] dst fixed, [2] irq enable
- 4 STATUS ro: [0] done, [1] busy, [2] error, [3] aborted
- 5 CMD wo: [0] start, [1] abort
- 6-7 read 0, writes ignored
REQ-011 SHALL apply writes in the cycle chipselect&write is seen; avs_s1_waitrequest SHALL be 0 for writes.
REQ-012 SHALL give slave reads exactly one wait state: waitrequest=1 in the first read cycle, then 0 with readdata valid in the next cycle.
REQ-013 SHALL ignore writes to S_ADDR/D_ADDR/LENGTH/CONTROL while busy=1; those registers SHALL hold their values.
REQ-014 SHALL, on CMD start with busy=0, do the following in the next cycle:
- clear done, error and aborted
- set busy
- load beat count N = LENGTH/BYTES
- load the read and write address pointers
REQ-015 SHALL, if LENGTH=0 or LENGTH mod BYTES != 0 at start, perform no master access and, one cycle later, set error=1 and done=1 with busy=0.
REQ-016 SHALL ignore CMD start while busy=1.
REQ-017 SHALL run read and write engines concurrently, coupled through the FIFO; the FIFO SHALL store words only, and its count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-018 The read engine SHALL drive the read master as follows:
- assert avm_read_read only while FIFO not full and reads issued < N
- hold address/read stable until waitrequest=0
- capture readdata into the FIFO in the cycle waitrequest=0
REQ-019 The write engine SHALL drive the write master as follows:
- assert avm_write_write with the FIFO head word whenever FIFO not empty
- hold address/data/write stable until waitrequest=0
- pop the FIFO and count the beat in that cycle
REQ-020 SHALL advance each address pointer by BYTES per completed beat unless its CONTROL fixed bit is set; addresses wrap modulo 2^32.
REQ-021 SHALL support simultaneous push and pop in one cycle with the count unchanged; a full FIFO SHALL accept a push in the same cycle as a pop.
REQ-022 SHALL, when the write beat count reaches N, set done=1 and busy=0 in the next cycle; exactly N reads and N writes SHALL occur.
REQ-023 SHALL handle CMD abort while busy as follows:
- issue no new accesses
- complete any access currently held under waitrequest
- flush the FIFO
- then set aborted=1, done=1, busy=0
REQ-024 SHALL ignore CMD abort while idle.
REQ-025 SHALL prioritise abort over completion if both occur in the same cycle.
REQ-026 SHALL clear STATUS.done when a slave read of STATUS completes; a done set in that same cycle SHALL win.

Reset
REQ-027 SHALL, on reset, clear all registers, the FIFO, the counts, irq, avm_read_read, avm_write_write, avs_s1_waitrequest and all addresses/data outputs to 0.
REQ-028 SHALL abandon any in-flight transfer on reset; the block SHALL be idle in the first cycle after reset deasserts.

Verification
REQ-029 Transfer: DATA_W=16, S=0x100, D=0x200, LENGTH=8, zero-wait slaves -> 4 reads at 0x100/102/104/106, 4 writes at 0x200..0x206 carrying the same data; STATUS then reads 0x1.
REQ-030 Fixed source and backpressure: CONTROL=1, LENGTH=16, DATA_W=32, write waitrequest held high 20 cycles -> FIFO fills to FIFO_DEPTH with reads stalled; all reads at S; writes at D..D+12; STATUS.done=1.
REQ-031 Bad length: LENGTH=3 with DATA_W=16 -> no master access; STATUS=0x5.
REQ-032 Abort: abort after 2 write beats of LENGTH=32 -> held access completes, no further accesses; STATUS=0x9; with CONTROL[2]=1, irq=1.
REQ-033 Start while busy: second start mid-transfer -> ignored, beat total unchanged; register writes while busy leave LENGTH unchanged.
REQ-034 Reset mid-operation: reset during WAIT on both masters -> next cycle read/write=0, STATUS=0, FIFO empty.

Source files
------------

// File: rtl/sdram_dma_fifo.sv
// Memory-to-memory DMA engine. An Avalon-MM register slave sets up the transfer;
// a read master and a write master run concurrently and are coupled by a word FIFO.
module sdram_dma_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_s1_chipselect,
  input  logic [2:0]        avs_s1_address,
  input  logic              avs_s1_read,
  input  logic              avs_s1_write,
  input  logic [31:0]       avs_s1_writedata,
  input  logic [3:0]        avs_s1_byteenable,
  output logic [31:0]       avs_s1_readdata,
  output logic              avs_s1_waitrequest,
  output logic [31:0]       avm_read_address,
  output logic              avm_read_read,
  input  logic [DATA_W-1:0] avm_read_readdata,
  input  logic              avm_read_waitrequest,
  output logic [31:0]       avm_write_address,
  output logic              avm_write_write,
  output logic [DATA_W-1:0] avm_write_writedata,
  input  logic              avm_write_waitrequest,
  output logic              irq
);
  localparam int          BYTES = DATA_W / 8;
  localparam int          BSH   = $clog2(BYTES);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [31:0] STEP  = 32'(BYTES);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ABORT, ST_ERR} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_s_addr, r_d_addr, r_length, r_beats;
  logic [31:0]       r_rd_cnt, r_wr_cnt, r_rd_ptr, r_wr_ptr, r_readdata;
  logic [2:0]        r_control;
  logic              r_done, r_error, r_aborted;
  logic              r_rd_req, r_wr_req, r_rd_phase;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_head, r_tail;
  logic [AW:0]       r_count;

  logic        w_busy, w_reg_wr, w_reg_rd, w_cmd, w_start, w_abort, w_len_bad;
  logic        w_rd_ack, w_wr_ack, w_issue, w_flush, w_stat_clr;
  logic        w_set_done, w_set_err, w_set_abt, w_rd_req_nxt, w_wr_req_nxt;
  logic [31:0] w_rd_cnt_nxt, w_wr_cnt_nxt, w_rdata;
  logic [AW:0] w_count_nxt;
  logic        w_unused;

  assign w_unused     = &{1'b0, avs_s1_byteenable};
  assign w_busy       = (r_state != ST_IDLE);
  assign w_reg_wr     = avs_s1_chipselect & avs_s1_write;
  assign w_reg_rd     = avs_s1_chipselect & avs_s1_read;
  assign w_cmd        = w_reg_wr & (avs_s1_address == 3'd5);
  assign w_start      = w_cmd & avs_s1_writedata[0] & ~w_busy;
  assign w_abort      = w_cmd & avs_s1_writedata[1] & (r_state == ST_RUN);
  assign w_len_bad    = (r_length == '0) | (r_length[BSH-1:0] != '0);
  assign w_stat_clr   = w_reg_rd & r_rd_phase & (avs_s1_address == 3'd4);
  assign w_rd_ack     = r_rd_req & ~avm_read_waitrequest;
  assign w_wr_ack     = r_wr_req & ~avm_write_waitrequest;
  assign w_rd_cnt_nxt = r_rd_cnt + 32'(w_rd_ack);
  assign w_wr_cnt_nxt = r_wr_cnt + 32'(w_wr_ack);
  assign w_count_nxt  = r_count + (AW + 1)'(w_rd_ack) - (AW + 1)'(w_wr_ack);

  // A request stuck under waitrequest is always held; new ones need room and budget.
  assign w_rd_req_nxt = (r_rd_req & avm_read_waitrequest) |
                        (w_issue & (w_rd_cnt_nxt < r_beats) & (w_count_nxt < DEPTH));
  assign w_wr_req_nxt = (r_wr_req & avm_write_waitrequest) |
                        (w_issue & (w_count_nxt != '0));

  assign avs_s1_waitrequest  = w_reg_rd & ~r_rd_phase & ~reset;
  assign avs_s1_readdata     = r_readdata;
  assign avm_read_address    = r_rd_ptr;
  assign avm_read_read       = r_rd_req;
  assign avm_write_address   = r_wr_ptr;
  assign avm_write_write     = r_wr_req;
  assign avm_write_writedata = r_wr_req ? r_mem[r_head] : '0;
  assign irq                 = r_done & r_control[2];

  always_comb begin
    w_rdata = '0;
    case (avs_s1_address)
      3'd0:    w_rdata = r_s_addr;
      3'd1:    w_rdata = r_d_addr;
      3'd2:    w_rdata = r_length;
      3'd3:    w_rdata = {29'd0, r_control};
      3'd4:    w_rdata = {28'd0, r_aborted, r_error, w_busy, r_done};
      default: w_rdata = '0;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_flush     = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_set_abt   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = w_len_bad ? ST_ERR : ST_RUN;
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
        w_set_done  = 1'b1;
        w_set_err   = 1'b1;
      end
      ST_RUN: begin
        w_issue = ~w_abort;
        if (w_abort) begin
          w_state_nxt = ST_ABORT;
        end else if (w_wr_cnt_nxt == r_beats) begin
          w_state_nxt = ST_IDLE;
          w_set_done  = 1'b1;
        end
      end
      ST_ABORT: if (!r_rd_req && !r_wr_req) begin
        w_state_nxt = ST_IDLE;
        w_flush     = 1'b1;
        w_set_done  = 1'b1;
        w_set_abt   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: storage has no reset; pointers and count empty the FIFO, and writedata is gated.
  always_ff @(posedge clk) begin
    if (w_rd_ack) r_mem[r_tail] <= avm_read_readdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_s_addr   <= '0;
      r_d_addr   <= '0;
      r_length   <= '0;
      r_control  <= '0;
      r_beats    <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_readdata <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_aborted  <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_phase <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_phase <= w_reg_rd & ~r_rd_phase;
      if (w_reg_rd && !r_rd_phase) r_readdata <= w_rdata;

      if (w_reg_wr && !w_busy) begin
        case (avs_s1_address)
          3'd0:    r_s_addr  <= avs_s1_writedata;
          3'd1:    r_d_addr  <= avs_s1_writedata;
          3'd2:    r_length  <= avs_s1_writedata;
          3'd3:    r_control <= avs_s1_writedata[2:0];
          default: ;
        endcase
      end

      // A completion in the same cycle as a STATUS read keeps done set.
      if (w_set_done)                 r_done    <= 1'b1;
      else if (w_start || w_stat_clr) r_done    <= 1'b0;
      if (w_set_err)                  r_error   <= 1'b1;
      else if (w_start)               r_error   <= 1'b0;
      if (w_set_abt)                  r_aborted <= 1'b1;
      else if (w_start)               r_aborted <= 1'b0;

      r_rd_req <= w_rd_req_nxt;
      r_wr_req <= w_wr_req_nxt;

      if (w_start) begin
        r_beats  <= r_length >> BSH;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
        r_rd_ptr <= r_s_addr;
        r_wr_ptr <= r_d_addr;
      end else begin
        r_rd_cnt <= w_rd_cnt_nxt;
        r_wr_cnt <= w_wr_cnt_nxt;
        if (w_rd_ack && !r_control[0]) r_rd_ptr <= r_rd_ptr + STEP;
        if (w_wr_ack && !r_control[1]) r_wr_ptr <= r_wr_ptr + STEP;
      end

      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_rd_ack) r_tail <= r_tail + AW'(1);
        if (w_wr_ack) r_head <= r_head + AW'(1);
        r_count <= w_count_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sdram_dma_fifo.sv
// Directed bench: instance A (16-bit, depth 8) and instance B (32-bit, depth 2)
// share the slave bus but have separate chipselects and master-side slave models.
module tb_sdram_dma_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cs_a, cs_b, s_rd, s_wr;
  logic [2:0]  s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [31:0] rdata_a, rdata_b;
  logic        wreq_a, wreq_b, irq_a, irq_b;
  logic [31:0] ra_addr, wa_addr;
  logic        ra_read, ra_wait, wa_write, wa_wait;
  logic [15:0] ra_rdata, wa_wdata;
  logic [31:0] rb_addr, wb_addr, rb_rdata, wb_wdata;
  logic        rb_read, rb_wait, wb_write, wb_wait;

  int n_checks = 0;
  int n_errors = 0;
  logic        last_wr_wait;
  logic [31:0] a_rd_q[$], a_wr_q[$], a_rdat_q[$], a_wdat_q[$];
  logic [31:0] b_rd_q[$], b_wr_q[$], b_rdat_q[$], b_wdat_q[$];

  assign ra_rdata = ra_addr[15:0] ^ 16'h5A5A;
  assign rb_rdata = rb_addr ^ 32'h1234_5678;

  sdram_dma_fifo #(.DATA_W(16), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .reset(reset),
    .avs_s1_chipselect(cs_a), .avs_s1_address(s_addr), .avs_s1_read(s_rd),
    .avs_s1_write(s_wr), .avs_s1_writedata(s_wdata), .avs_s1_byteenable(s_be),
    .avs_s1_readdata(rdata_a), .avs_s1_waitrequest(wreq_a),
    .avm_read_address(ra_addr), .avm_read_read(ra_read),
    .avm_read_readdata(ra_rdata), .avm_read_waitrequest(ra_wait),
    .avm_write_address(wa_addr), .avm_write_write(wa_write),
    .avm_write_writedata(wa_wdata), .avm_write_waitrequest(wa_wait),
    .irq(irq_a)
  );

  sdram_dma_fifo #(.DATA_W(32), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .reset(reset),
    .avs_s1_chipselect(cs_b), .avs_s1_address(s_addr), .avs_s1_read(s_rd),
    .avs_s1_write(s_wr), .avs_s1_writedata(s_wdata), .avs_s1_byteenable(s_be),
    .avs_s1_readdata(rdata_b), .avs_s1_waitrequest(wreq_b),
    .avm_read_address(rb_addr), .avm_read_read(rb_read),
    .avm_read_readdata(rb_rdata), .avm_read_waitrequest(rb_wait),
    .avm_write_address(wb_addr), .avm_write_write(wb_write),
    .avm_write_writedata(wb_wdata), .avm_write_waitrequest(wb_wait),
    .irq(irq_b)
  );

  always @(posedge clk) begin
    if (!reset) begin
      if (ra_read && !ra_wait)   begin a_rd_q.push_back(ra_addr); a_rdat_q.push_back({16'h0, ra_rdata}); end
      if (wa_write && !wa_wait)  begin a_wr_q.push_back(wa_addr); a_wdat_q.push_back({16'h0, wa_wdata}); end
      if (rb_read && !rb_wait)   begin b_rd_q.push_back(rb_addr); b_rdat_q.push_back(rb_rdata); end
      if (wb_write && !wb_wait)  begin b_wr_q.push_back(wb_addr); b_wdat_q.push_back(wb_wdata); end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    a_rd_q.delete(); a_wr_q.delete(); a_rdat_q.delete(); a_wdat_q.delete();
    b_rd_q.delete(); b_wr_q.delete(); b_rdat_q.delete(); b_wdat_q.delete();
  endtask

  task automatic reg_wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cs_a = !sel; cs_b = sel; s_addr = a; s_wr = 1'b1; s_wdata = d;
    #1 last_wr_wait = sel ? wreq_b : wreq_a;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; s_wr = 1'b0;
  endtask

  task automatic reg_rd(input bit sel, input logic [2:0] a, output logic [31:0] d,
                        output logic w1, output logic w2);
    @(negedge clk);
    cs_a = !sel; cs_b = sel; s_addr = a; s_rd = 1'b1;
    #1 w1 = sel ? wreq_b : wreq_a;
    @(negedge clk);
    w2 = sel ? wreq_b : wreq_a;
    d  = sel ? rdata_b : rdata_a;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; s_rd = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, output logic [31:0] st);
    logic w1, w2;
    st = 32'h2;
    for (int i = 0; i < 200; i++) begin
      reg_rd(sel, 3'd4, st, w1, w2);
      if (!st[1]) break;
    end
  endtask

  task automatic setup(input bit sel, input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] len, input logic [31:0] ctl);
    reg_wr(sel, 3'd0, s);
    reg_wr(sel, 3'd1, d);
    reg_wr(sel, 3'd2, len);
    reg_wr(sel, 3'd3, ctl);
  endtask

  initial begin
    logic [31:0] st, v;
    logic        w1, w2;
    int          n_rd;

    reset = 1'b1; cs_a = 1'b0; cs_b = 1'b0; s_rd = 1'b0; s_wr = 1'b0;
    s_addr = '0; s_wdata = '0; s_be = 4'hF;
    ra_wait = 1'b0; wa_wait = 1'b0; rb_wait = 1'b0; wb_wait = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_read", 32'(ra_read), 32'h0);
    check("rst_write", 32'(wa_write), 32'h0);
    check("rst_irq", 32'(irq_a), 32'h0);
    check("rst_wdata", 32'(wa_wdata), 32'h0);
    check("rst_waitreq", 32'(wreq_a), 32'h0);
    reg_rd(1'b0, 3'd4, st, w1, w2);
    check("rst_status", st, 32'h0);
    check("rd_wait1", 32'(w1), 32'h1);
    check("rd_wait2", 32'(w2), 32'h0);

    // Plain 16-bit copy, zero-wait slaves.
    setup(1'b0, 32'h100, 32'h200, 32'd8, 32'd0);
    check("wr_no_wait", 32'(last_wr_wait), 32'h0);
    reg_rd(1'b0, 3'd2, v, w1, w2);
    check("len_readback", v, 32'd8);
    clear_q();
    reg_wr(1'b0, 3'd5, 32'h1);
    wait_idle(1'b0, st);
    check("t1_status", st, 32'h1);
    reg_rd(1'b0, 3'd4, st, w1, w2);
    check("t1_done_clr", st, 32'h0);
    check("t1_nrd", 32'(a_rd_q.size()), 32'd4);
    check("t1_nwr", 32'(a_wr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < a_rd_q.size() && i < a_wr_q.size(); i++) begin
      check($sformatf("t1_raddr%0d", i), a_rd_q[i], 32'h100 + 32'(2 * i));
      check($sformatf("t1_waddr%0d", i), a_wr_q[i], 32'h200 + 32'(2 * i));
      check($sformatf("t1_wdata%0d", i), a_wdat_q[i],
            {16'h0, 16'(32'h100 + 32'(2 * i)) ^ 16'h5A5A});
    end

    // Length not a multiple of the beat size.
    setup(1'b0, 32'h100, 32'h200, 32'd3, 32'd0);
    clear_q();
    reg_wr(1'b0, 3'd5, 32'h1);
    wait_idle(1'b0, st);
    check("t2_status", st, 32'h5);
    check("t2_nacc", 32'(a_rd_q.size() + a_wr_q.size()), 32'd0);

    // 32-bit, fixed source, write backpressure against a depth-2 FIFO.
    setup(1'b1, 32'h1000, 32'h2000, 32'd16, 32'd1);
    clear_q();
    wb_wait = 1'b1;
    reg_wr(1'b1, 3'd5, 32'h1);
    repeat (20) @(negedge clk);
    check("t3_stall_nrd", 32'(b_rd_q.size()), 32'd2);
    check("t3_held_wr", 32'(wb_write), 32'h1);
    check("t3_held_addr", wb_addr, 32'h2000);
    wb_wait = 1'b0;
    wait_idle(1'b1, st);
    check("t3_status", st, 32'h1);
    check("t3_nrd", 32'(b_rd_q.size()), 32'd4);
    check("t3_nwr", 32'(b_wr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < b_rd_q.size() && i < b_wr_q.size(); i++) begin
      check($sformatf("t3_raddr%0d", i), b_rd_q[i], 32'h1000);
      check($sformatf("t3_waddr%0d", i), b_wr_q[i], 32'h2000 + 32'(4 * i));
      check($sformatf("t3_wdata%0d", i), b_wdat_q[i], 32'h1234_4678);
    end

    // Second start and register writes while busy are ignored.
    setup(1'b0, 32'h300, 32'h400, 32'd8, 32'd0);
    clear_q();
    wa_wait = 1'b1;
    reg_wr(1'b0, 3'd5, 32'h1);
    repeat (6) @(negedge clk);
    reg_wr(1'b0, 3'd2, 32'd100);
    reg_wr(1'b0, 3'd5, 32'h1);
    reg_rd(1'b0, 3'd2, v, w1, w2);
    check("t4_len_kept", v, 32'd8);
    reg_rd(1'b0, 3'd4, st, w1, w2);
    check("t4_busy", st, 32'h2);
    wa_wait = 1'b0;
    wait_idle(1'b0, st);
    check("t4_status", st, 32'h1);
    check("t4_nrd", 32'(a_rd_q.size()), 32'd4);
    check("t4_nwr", 32'(a_wr_q.size()), 32'd4);

    // Abort with the third write held under waitrequest.
    setup(1'b0, 32'h500, 32'h600, 32'd32, 32'd4);
    clear_q();
    wa_wait = 1'b1;
    reg_wr(1'b0, 3'd5, 32'h1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 50 && !wa_write; i++) @(negedge clk);
      wa_wait = 1'b0;
      @(negedge clk);
      wa_wait = 1'b1;
    end
    repeat (2) @(negedge clk);
    check("t5_held_wr", 32'(wa_write), 32'h1);
    check("t5_held_addr", wa_addr, 32'h604);
    reg_wr(1'b0, 3'd5, 32'h2);
    n_rd = a_rd_q.size();
    repeat (3) @(negedge clk);
    check("t5_no_new_rd", 32'(ra_read), 32'h0);
    wa_wait = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_irq", 32'(irq_a), 32'h1);
    check("t5_nrd", 32'(a_rd_q.size()), 32'(n_rd));
    check("t5_nwr", 32'(a_wr_q.size()), 32'd3);
    wait_idle(1'b0, st);
    check("t5_status", st, 32'h9);
    check("t5_irq_clr", 32'(irq_a), 32'h0);

    // Reset while both masters are stalled.
    setup(1'b0, 32'h700, 32'h800, 32'd32, 32'd0);
    clear_q();
    wa_wait = 1'b1;
    reg_wr(1'b0, 3'd5, 32'h1);
    repeat (6) @(negedge clk);
    ra_wait = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rd_wait", 32'(ra_read), 32'h1);
    check("t6_wr_wait", 32'(wa_write), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rd_off", 32'(ra_read), 32'h0);
    check("t6_wr_off", 32'(wa_write), 32'h0);
    check("t6_raddr", ra_addr, 32'h0);
    check("t6_waddr", wa_addr, 32'h0);
    ra_wait = 1'b0;
    wa_wait = 1'b0;
    clear_q();
    repeat (5) @(negedge clk);
    check("t6_fifo_empty", 32'(a_wr_q.size() + a_rd_q.size()), 32'd0);
    reg_rd(1'b0, 3'd4, st, w1, w2);
    check("t6_status", st, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
